// File: rtl/kick_charge_ctrl.sv
// kick_charge_ctrl: filters ADC supply/capacitor samples and runs the kicker capacitor charge FSM
//   in : clk, reset (sync, active-high), powv/pow_valid and capv/cap_valid (ADC samples + 1-cycle strobes),
//        charge_req (CPU level request), fault_clr (1-cycle strobe)
//   out: charge_en (charger pin), cap_full, low_bat, fault, pow_avg, cap_avg, primed (registered)
module kick_charge_ctrl #(
  parameter logic [7:0] CAP_FULL_TH  = 8'd200,
  parameter logic [7:0] CAP_RECHG_TH = 8'd180,
  parameter logic [7:0] BAT_LOW_TH   = 8'd150,
  parameter logic [7:0] BAT_OK_TH    = 8'd160,
  parameter int TMO_W = 24,
  parameter logic [TMO_W-1:0] CHG_TIMEOUT = TMO_W'(10000000)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] powv,
  input  logic       pow_valid,
  input  logic [7:0] capv,
  input  logic       cap_valid,
  input  logic       charge_req,
  input  logic       fault_clr,
  output logic       charge_en,
  output logic       cap_full,
  output logic       low_bat,
  output logic       fault,
  output logic [7:0] pow_avg,
  output logic [7:0] cap_avg,
  output logic       primed
);
  typedef enum logic [1:0] {IDLE, CHARGING, FULL, FAULT} state_t;
  localparam logic [TMO_W-1:0] TMO_LAST = CHG_TIMEOUT - TMO_W'(1);
  state_t state_q, state_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [3:0][7:0] pow_hist_q, pow_hist_d, cap_hist_q, cap_hist_d;
  logic [9:0] pow_sum_q, pow_sum_d, cap_sum_q, cap_sum_d;
  logic [2:0] pow_cnt_q, pow_cnt_d, cap_cnt_q, cap_cnt_d;
  logic [7:0] pow_avg_q, pow_avg_d, cap_avg_q, cap_avg_d;
  logic primed_q, primed_d, low_bat_q, low_bat_d;
  logic charge_en_q, charge_en_d, cap_full_q, cap_full_d, fault_q, fault_d;
  // Moving-average filters: entry [3] is the oldest sample, dropped from the running sum as a new one enters.
  always_comb begin
    pow_hist_d = pow_valid ? {pow_hist_q[2:0], powv} : pow_hist_q;
    cap_hist_d = cap_valid ? {cap_hist_q[2:0], capv} : cap_hist_q;
    pow_sum_d = pow_valid ? pow_sum_q + 10'(powv) - 10'(pow_hist_q[3]) : pow_sum_q;
    cap_sum_d = cap_valid ? cap_sum_q + 10'(capv) - 10'(cap_hist_q[3]) : cap_sum_q;
    pow_cnt_d = (pow_valid && !pow_cnt_q[2]) ? pow_cnt_q + 3'd1 : pow_cnt_q;
    cap_cnt_d = (cap_valid && !cap_cnt_q[2]) ? cap_cnt_q + 3'd1 : cap_cnt_q;
    pow_avg_d = pow_sum_d[9:2];
    cap_avg_d = cap_sum_d[9:2];
    primed_d = pow_cnt_d[2] && cap_cnt_d[2];
    low_bat_d = !primed_q ? low_bat_q :
                (pow_avg_q < BAT_LOW_TH) ? 1'b1 :
                (pow_avg_q >= BAT_OK_TH) ? 1'b0 : low_bat_q;
  end
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:
        if (charge_req && primed_q && !low_bat_q) begin
          state_d = CHARGING;
          timer_d = '0;
        end
      CHARGING:
        if (!charge_req || low_bat_q) state_d = IDLE;
        else if (cap_avg_q >= CAP_FULL_TH) state_d = FULL;
        else if (timer_q == TMO_LAST) state_d = FAULT;
        else timer_d = timer_q + TMO_W'(1);
      FULL:
        if (!charge_req || low_bat_q) state_d = IDLE;
        else if (cap_avg_q < CAP_RECHG_TH) begin
          state_d = CHARGING;
          timer_d = '0;
        end
      FAULT:
        if (fault_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they land together with the state register.
    charge_en_d = state_d == CHARGING;
    cap_full_d = state_d == FULL;
    fault_d = state_d == FAULT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      pow_hist_q <= '0;
      cap_hist_q <= '0;
      pow_sum_q <= '0;
      cap_sum_q <= '0;
      pow_cnt_q <= '0;
      cap_cnt_q <= '0;
      pow_avg_q <= '0;
      cap_avg_q <= '0;
      primed_q <= 1'b0;
      low_bat_q <= 1'b0;
      charge_en_q <= 1'b0;
      cap_full_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pow_hist_q <= pow_hist_d;
      cap_hist_q <= cap_hist_d;
      pow_sum_q <= pow_sum_d;
      cap_sum_q <= cap_sum_d;
      pow_cnt_q <= pow_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      pow_avg_q <= pow_avg_d;
      cap_avg_q <= cap_avg_d;
      primed_q <= primed_d;
      low_bat_q <= low_bat_d;
      charge_en_q <= charge_en_d;
      cap_full_q <= cap_full_d;
      fault_q <= fault_d;
    end
  end
  assign charge_en = charge_en_q;
  assign cap_full = cap_full_q;
  assign low_bat = low_bat_q;
  assign fault = fault_q;
  assign pow_avg = pow_avg_q;
  assign cap_avg = cap_avg_q;
  assign primed = primed_q;
endmodule

// File: tb/tb_kick_charge_ctrl.sv
// tb_kick_charge_ctrl: directed self-checking bench for kick_charge_ctrl with a 100-cycle charge timeout
module tb_kick_charge_ctrl;
  logic clk = 1'b0;
  logic reset, pow_valid, cap_valid, charge_req, fault_clr;
  logic [7:0] powv, capv;
  logic charge_en, cap_full, low_bat, fault, primed;
  logic [7:0] pow_avg, cap_avg;
  int n_cmp = 0;
  int n_bad = 0;
  kick_charge_ctrl #(.CHG_TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset), .powv(powv), .pow_valid(pow_valid), .capv(capv), .cap_valid(cap_valid),
    .charge_req(charge_req), .fault_clr(fault_clr), .charge_en(charge_en), .cap_full(cap_full),
    .low_bat(low_bat), .fault(fault), .pow_avg(pow_avg), .cap_avg(cap_avg), .primed(primed)
  );
  always #5 clk = ~clk;
  task automatic step(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pow(input logic [7:0] v, input int k = 1);
    for (int i = 0; i < k; i++) begin
      powv = v;
      pow_valid = 1'b1;
      step();
      pow_valid = 1'b0;
    end
  endtask
  task automatic cap(input logic [7:0] v, input int k = 1);
    for (int i = 0; i < k; i++) begin
      capv = v;
      cap_valid = 1'b1;
      step();
      cap_valid = 1'b0;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1; pow_valid = 1'b0; cap_valid = 1'b0; charge_req = 1'b0; fault_clr = 1'b0;
    powv = '0; capv = '0;
    step(2);
    reset = 1'b0;
    chk("rst_outs", {charge_en, cap_full, low_bat, fault, primed}, 0);
    chk("rst_avgs", {pow_avg, cap_avg}, 0);
    pow(8'd200);
    chk("pow_avg_1st", pow_avg, 50);
    pow(8'd200, 3);
    chk("pow_avg_full", pow_avg, 200);
    cap(8'd40, 3);
    chk("not_primed_3cap", primed, 0);
    cap(8'd40);
    chk("primed", primed, 1);
    chk("cap_avg_40", cap_avg, 40);
    step();
    chk("low_bat_ok", low_bat, 0);
    chk("idle_no_req", charge_en, 0);
    charge_req = 1'b1;
    step();
    chk("chg_start", charge_en, 1);
    for (int v = 60; v <= 220; v += 20) cap(8'(v));
    chk("ramp_avg", cap_avg, 190);
    step();
    chk("ramp_still_chg", {charge_en, cap_full}, 2'b10);
    cap(8'd220);
    chk("ramp_avg2", cap_avg, 205);
    step();
    chk("full_reached", {charge_en, cap_full}, 2'b01);
    cap(8'd190, 4);
    step();
    chk("full_hold_190", {charge_en, cap_full}, 2'b01);
    cap(8'd170, 2);
    chk("avg_at_rechg", cap_avg, 180);
    chk("full_at_180", cap_full, 1);
    cap(8'd170, 2);
    chk("rechg", {charge_en, cap_full}, 2'b10);
    cap(8'd40, 4);
    step(95);
    chk("pre_timeout", {charge_en, fault}, 2'b10);
    step();
    chk("timeout", {charge_en, fault}, 2'b01);
    step(5);
    chk("fault_held", {charge_en, fault}, 2'b01);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("fault_clr", {charge_en, fault}, 2'b00);
    step();
    chk("rechg_after_clr", charge_en, 1);
    pow(8'd140, 4);
    chk("pow_avg_140", pow_avg, 140);
    step();
    chk("low_bat_set", low_bat, 1);
    step();
    chk("low_bat_stop", charge_en, 0);
    step(3);
    chk("low_bat_idle", charge_en, 0);
    pow(8'd155, 4);
    step(2);
    chk("low_bat_hyst", {low_bat, charge_en}, 2'b10);
    pow(8'd165, 4);
    chk("pow_avg_165", pow_avg, 165);
    chk("low_bat_clr_resume", {low_bat, charge_en}, 2'b01);
    step(2);
    chk("pre_rst_chg", charge_en, 1);
    reset = 1'b1; powv = 8'd200; capv = 8'd40; pow_valid = 1'b1; cap_valid = 1'b1;
    step();
    reset = 1'b0; pow_valid = 1'b0; cap_valid = 1'b0;
    chk("mid_rst_outs", {charge_en, cap_full, low_bat, fault, primed}, 0);
    chk("mid_rst_avgs", {pow_avg, cap_avg}, 0);
    pow(8'd200);
    chk("post_rst_avg", pow_avg, 50);
    pow(8'd200, 2);
    cap(8'd40, 4);
    chk("post_rst_not_primed", primed, 0);
    pow(8'd200);
    chk("post_rst_primed", primed, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
